n8_responder: RTL
=================

# n8_responder

Device-side end of the N8 controller serial link: answers the latch/pulse strobes issued by `n8_driver` by shifting out eight button states on a single data line. The block lets a DE1_SoC build act as an N8 controller for another board, and serves as the in-bench controller model for `n8_driver` regression. It sits between board switches/keys (or a bench stimulus) and the GPIO pins carrying latch, pulse and data.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in each input synchronizer for `latch_in`/`pulse_in`; legal values are 2–4.
- `TURBO_DIV`, 4: number of frames per turbo half-period; legal range is 1–15. Used only with turbo compiled in.

Ports:
- `clk`  input  1  system clock, CLOCK_50 domain.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `latch_in`  input  1  latch strobe from the reader; asynchronous; high = capture.
- `pulse_in`  input  1  shift clock from the reader; asynchronous; each rising edge advances one bit.
- `buttons`  input  8  button states, active-high pressed, synchronous to `clk`. Bit order: [0]A [1]B [2]select [3]start [4]up [5]down [6]left [7]right.
- `data_out`  output  1  serial data, registered, active-low (0 = pressed).
- `frame_done`  output  1  one-cycle pulse when the 8th bit has been shifted past.
- `extra_pulse`  output  1  sticky flag: a pulse edge was seen after the frame was exhausted.
- `bit_count`  output  4  index of the bit currently on `data_out`, 0–8.

## Operation
- Synchronize `latch_in` and `pulse_in` through `SYNC_STAGES` flops each. The pulse rising edge is the synchronized value AND NOT its one-cycle-delayed copy.
- FSM states:
  - IDLE: reset state. `data_out`=1.
  - LOAD: entered while the synchronized latch is 1, from any state. Every cycle: shift register ← `buttons`, `bit_count`←0, `extra_pulse`←0, `data_out`←~`buttons[0]`. Pulse edges are ignored.
  - SHIFT: entered when latch falls. On each pulse edge: shift register shifts right with 1 filled in, `bit_count`+1, and `data_out`←~next bit. When `bit_count` goes 7→8: `data_out`←1, `frame_done` pulses, go to DONE.
  - DONE: `data_out`=1 and `bit_count` holds at 8. Each pulse edge sets `extra_pulse`. Latch high → LOAD.
- Latch has priority: if latch is high and a pulse edge arrives in the same cycle, the edge is dropped.
- If latch rises mid-SHIFT, the frame is aborted and reloaded without pulsing `frame_done`.
- `bit_count` saturates at 8 and never wraps.
- Asserting `reset_n` low at any time forces every output to its reset value immediately, and the synchronizers clear to 0.

## Timing
- Reset values: `data_out`=1, `frame_done`=0, `extra_pulse`=0, `bit_count`=0, state IDLE.
- Input pin to recognized event: `SYNC_STAGES` cycles, plus 1 cycle for edge detect.
- Pulse pin rising edge to new `data_out`: `SYNC_STAGES`+1 cycles. This is 3 cycles (60 ns) at the default setting.
  - The reader must sample `data_out` at least `SYNC_STAGES`+2 cycles after its pulse edge.
  - Pulse high and low times must each be ≥ `SYNC_STAGES`+1 cycles.
- Latch pin high to `data_out` = ~`buttons[0]`: `SYNC_STAGES`+1 cycles.
- `frame_done` is asserted in the same cycle that `data_out` goes to 1 after bit 7.

## Configuration
- `N8_RESP_TURBO_EN` defined: a 4-bit frame counter increments on every LOAD→SHIFT transition and wraps at `TURBO_DIV`; a turbo phase bit toggles on each wrap. While the phase bit is 0, `buttons[0]` and `buttons[1]` are masked to 0 at load. Phase and counter reset to 0.
- `N8_RESP_TURBO_EN` undefined: buttons are loaded unmodified, and no counter or phase logic is present.

## Test plan
- Reset with `buttons`=8'h00, no strobes → `data_out`=1, `bit_count`=0, `frame_done`=0, `extra_pulse`=0.
- `buttons`=8'hA5, latch 12 cycles, then 8 pulses (8 cycles high / 8 cycles low), sampling 4 cycles after each edge → data stream 0,1,0,1,1,0,1,0. `frame_done` pulses once after the 8th edge, and `data_out`=1 after it.
- Same frame with 10 pulses → `bit_count`=8, `data_out`=1, `extra_pulse`=1. The next latch clears `extra_pulse` to 0.
- `buttons`=8'hFF, latch, 3 pulses, then latch again with `buttons`=8'h01 → no `frame_done`; after the new latch, `data_out`=0 and `bit_count`=0.
- Pulse edge with latch held high → `bit_count` stays 0 and `data_out` tracks ~`buttons[0]`. Assert `reset_n` mid-SHIFT → all outputs return to reset values the same cycle.
- With `N8_RESP_TURBO_EN`, `TURBO_DIV`=2, `buttons`=8'h03, frames 1–6 → the first bit is 1,1,0,0,1,1.

Source files
------------

// File: rtl/n8_responder.sv
// Device side of the N8 controller link: answers latch/pulse strobes by shifting
// out eight active-low button states. Optional turbo masking via N8_RESP_TURBO_EN.
module n8_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TURBO_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       latch_in,
  input  logic       pulse_in,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic       frame_done,
  output logic       extra_pulse,
  output logic [3:0] bit_count,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("n8_responder: SYNC_STAGES must be 2..4");
  end
  if (TURBO_DIV < 1 || TURBO_DIV > 15) begin : g_bad_turbo_div
    $error("n8_responder: TURBO_DIV must be 1..15");
  end

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] latch_sync, pulse_sync;
  logic                   pulse_d;
  logic                   latch_s, pulse_s, pulse_edge;
  logic [7:0]             load_val;
  // Bits 7..1 still to be sent; bit 0 goes straight to data_out at load.
  logic [6:0]             remain, remain_n;
  logic [3:0]             count_n;
  logic                   data_n, done_n, extra_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      pulse_d    <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pulse_in};
      pulse_d    <= pulse_sync[SYNC_STAGES-1];
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync[SYNC_STAGES-1];
  assign pulse_edge = pulse_s & ~pulse_d;

`ifdef N8_RESP_TURBO_EN
  localparam logic [3:0] TURBO_LAST = 4'(TURBO_DIV - 1);
  logic [3:0] frame_cnt;
  logic       turbo_phase;
  logic       frame_adv;

  // A frame is counted when the latch releases and shifting begins.
  assign frame_adv = (state == LOAD) && !latch_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= 4'd0;
      turbo_phase <= 1'b0;
    end else if (frame_adv) begin
      if (frame_cnt == TURBO_LAST) begin
        frame_cnt   <= 4'd0;
        turbo_phase <= ~turbo_phase;
      end else begin
        frame_cnt <= frame_cnt + 4'd1;
      end
    end
  end

  assign load_val = turbo_phase ? buttons : {buttons[7:2], 2'b00};
`else
  assign load_val = buttons;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      remain      <= '1;
      bit_count   <= 4'd0;
      data_out    <= 1'b1;
      frame_done  <= 1'b0;
      extra_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      remain      <= remain_n;
      bit_count   <= count_n;
      data_out    <= data_n;
      frame_done  <= done_n;
      extra_pulse <= extra_n;
    end
  end

  // Latch overrides every state, so a pulse edge coinciding with latch is dropped.
  always_comb begin
    state_n  = state;
    remain_n = remain;
    count_n  = bit_count;
    data_n   = data_out;
    done_n   = 1'b0;
    extra_n  = extra_pulse;
    if (latch_s) begin
      state_n  = LOAD;
      remain_n = load_val[7:1];
      count_n  = 4'd0;
      extra_n  = 1'b0;
      data_n   = ~load_val[0];
    end else begin
      case (state)
        IDLE: begin
          data_n = 1'b1;
        end
        LOAD: begin
          state_n = SHIFT;
        end
        SHIFT: begin
          if (pulse_edge) begin
            remain_n = {1'b1, remain[6:1]};
            if (bit_count == 4'd7) begin
              count_n = 4'd8;
              data_n  = 1'b1;
              done_n  = 1'b1;
              state_n = DONE;
            end else begin
              count_n = bit_count + 4'd1;
              data_n  = ~remain[0];
            end
          end
        end
        DONE: begin
          data_n  = 1'b1;
          count_n = 4'd8;
          if (pulse_edge) extra_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule
